pattern_scheduler: RTL and testbench

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

---
 rtl/muse_video_pkg.sv | 65 ++++++
 rtl/pattern_scheduler_if.sv | 32 +++
 rtl/video_timing.sv | 70 +++++++
 rtl/pattern_scheduler.sv | 134 +++++++++++++
 tb/tb_pattern_scheduler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/muse_video_pkg.sv
// ============================================================================
// Package : muse_video_pkg
// Brief   : 640x480@60 timing constants, colour constants, pattern encoding.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package muse_video_pkg;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FRONT  = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BACK   = 48;
    localparam int C_H_TOTAL  = 800;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FRONT  = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BACK   = 33;
    localparam int C_V_TOTAL  = 525;
    localparam int C_CNT_W    = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t C_BLACK   = 24'h000000;
    localparam rgb_t C_WHITE   = 24'hFFFFFF;
    localparam rgb_t C_RED     = 24'hFF0000;
    localparam rgb_t C_GREEN   = 24'h00FF00;
    localparam rgb_t C_BLUE    = 24'h0000FF;
    localparam rgb_t C_YELLOW  = 24'hFFFF00;
    localparam rgb_t C_CYAN    = 24'h00FFFF;
    localparam rgb_t C_MAGENTA = 24'hFF00FF;

    typedef enum logic [1:0] {
        PAT_RED     = 2'd0,
        PAT_BLUE    = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    // Nearest enabled pattern above cur (wrapping); cur itself when it is the only one.
    function automatic pattern_e next_pattern(input pattern_e cur, input logic [3:0] mask);
        logic [1:0] cand;
        next_pattern = cur;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'(int'(cur) + k);
            if (mask[cand]) next_pattern = pattern_e'(cand);
        end
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_colour = C_WHITE;
            3'd1:    bar_colour = C_YELLOW;
            3'd2:    bar_colour = C_CYAN;
            3'd3:    bar_colour = C_GREEN;
            3'd4:    bar_colour = C_MAGENTA;
            3'd5:    bar_colour = C_RED;
            3'd6:    bar_colour = C_BLUE;
            default: bar_colour = C_BLACK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_scheduler_if.sv
// ============================================================================
// Interface : pattern_scheduler_if
// Brief     : Scheduler configuration inputs and the pixel stream to HDMI.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pattern_scheduler_if;
    logic [7:0] holdFrames;
    logic [3:0] patternMask;
    logic       forceNext;
    logic [7:0] vgaRed;
    logic [7:0] vgaGreen;
    logic [7:0] vgaBlue;
    logic       hSync;
    logic       vSync;
    logic       dataEnable;
    logic       frameStart;
    logic [1:0] patternIdx;

    modport master (
        output holdFrames, patternMask, forceNext,
        input  vgaRed, vgaGreen, vgaBlue, hSync, vSync, dataEnable, frameStart, patternIdx
    );

    modport slave (
        input  holdFrames, patternMask, forceNext,
        output vgaRed, vgaGreen, vgaBlue, hSync, vSync, dataEnable, frameStart, patternIdx
    );
endinterface

`default_nettype wire

// File: rtl/video_timing.sv
// ============================================================================
// Module : video_timing
// Brief  : Horizontal/vertical counters with raw (unregistered) sync and DE.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing import muse_video_pkg::*; #(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_FRONT  = C_H_FRONT,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BACK   = C_H_BACK,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_FRONT  = C_V_FRONT,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BACK   = C_V_BACK
) (
    input  wire                clk_i,
    input  wire                rst_ni,
    output logic [C_CNT_W-1:0] h_count_o,
    output logic               v_cell_o,
    output logic               hsync_n_o,
    output logic               vsync_n_o,
    output logic               de_o,
    output logic               first_px_o,
    output logic               boundary_o
);

    localparam logic [C_CNT_W-1:0] H_LAST   = C_CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [C_CNT_W-1:0] V_LAST   = C_CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [C_CNT_W-1:0] H_ACT    = C_CNT_W'(H_ACTIVE);
    localparam logic [C_CNT_W-1:0] V_ACT    = C_CNT_W'(V_ACTIVE);
    localparam logic [C_CNT_W-1:0] HS_START = C_CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [C_CNT_W-1:0] HS_END   = C_CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [C_CNT_W-1:0] VS_START = C_CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [C_CNT_W-1:0] VS_END   = C_CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [C_CNT_W-1:0] h_q, h_d;
    logic [C_CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + C_CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o  = h_q;
    assign v_cell_o   = v_q[5];
    assign hsync_n_o  = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_n_o  = !((v_q >= VS_START) && (v_q < VS_END));
    assign de_o       = (h_q < H_ACT) && (v_q < V_ACT);
    assign first_px_o = (h_q == '0) && (v_q == '0);
    assign boundary_o = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

`default_nettype wire

// File: rtl/pattern_scheduler.sv
// ============================================================================
// Module : pattern_scheduler
// Brief  : Cycles test patterns frame by frame and drives registered video.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_scheduler import muse_video_pkg::*; #(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int H_FRONT  = C_H_FRONT,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BACK   = C_H_BACK,
    parameter int V_FRONT  = C_V_FRONT,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BACK   = C_V_BACK
) (
    input  wire                 pixelClk,
    input  wire                 reset,
    pattern_scheduler_if.slave  bus
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [C_CNT_W-1:0] w_h;
    logic               w_v_cell, w_hs_n, w_vs_n, w_de, w_first_px, w_boundary;

    video_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk_i      (pixelClk),
        .rst_ni     (reset),
        .h_count_o  (w_h),
        .v_cell_o   (w_v_cell),
        .hsync_n_o  (w_hs_n),
        .vsync_n_o  (w_vs_n),
        .de_o       (w_de),
        .first_px_o (w_first_px),
        .boundary_o (w_boundary)
    );

    pattern_e   idx_q, idx_d, idx_out_q;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] mask_q, mask_d;
    logic       pending_q, pending_d;
    rgb_t       rgb_q;
    logic       hs_q, vs_q, de_q, fs_q;

    logic [7:0] w_hold_last;
    logic       w_advance;
    logic [2:0] w_bar;
    rgb_t       w_rgb;

    // A force arriving on the boundary cycle itself is consumed by that boundary.
    always_comb begin
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        mask_d      = mask_q;
        pending_d   = pending_q | bus.forceNext;
        w_hold_last = (bus.holdFrames == 8'd0) ? 8'd0 : bus.holdFrames - 8'd1;
        w_advance   = 1'b0;
        if (w_boundary) begin
            mask_d    = bus.patternMask;
            pending_d = 1'b0;
            if (bus.patternMask == 4'd0) begin
                frame_cnt_d = 8'd0;
            end else begin
                w_advance = pending_q | bus.forceNext | (frame_cnt_q >= w_hold_last)
                          | !bus.patternMask[idx_q];
                if (w_advance) begin
                    idx_d       = next_pattern(idx_q, bus.patternMask);
                    frame_cnt_d = 8'd0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_bar = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (int'(w_h) >= b * BAR_W) w_bar = 3'(b);
        end
        case (idx_q)
            PAT_RED:     w_rgb = C_RED;
            PAT_BLUE:    w_rgb = C_BLUE;
            PAT_BARS:    w_rgb = bar_colour(w_bar);
            PAT_CHECKER: w_rgb = (w_h[5] ^ w_v_cell) ? C_BLACK : C_WHITE;
            default:     w_rgb = C_BLACK;
        endcase
        if (!w_de || (mask_q == 4'd0)) w_rgb = C_BLACK;
    end

    // The mask copy resets to all-enabled so the first frame after reset is visible.
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            idx_q       <= PAT_RED;
            idx_out_q   <= PAT_RED;
            frame_cnt_q <= 8'd0;
            mask_q      <= 4'hF;
            pending_q   <= 1'b0;
            rgb_q       <= C_BLACK;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            idx_out_q   <= idx_q;
            frame_cnt_q <= frame_cnt_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            rgb_q       <= w_rgb;
            hs_q        <= w_hs_n;
            vs_q        <= w_vs_n;
            de_q        <= w_de;
            fs_q        <= w_first_px;
        end
    end

    assign bus.vgaRed     = rgb_q[23:16];
    assign bus.vgaGreen   = rgb_q[15:8];
    assign bus.vgaBlue    = rgb_q[7:0];
    assign bus.hSync      = hs_q;
    assign bus.vSync      = vs_q;
    assign bus.dataEnable = de_q;
    assign bus.frameStart = fs_q;
    assign bus.patternIdx = idx_out_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_scheduler.sv
// ============================================================================
// Module : tb_pattern_scheduler
// Brief  : Directed bench: instance A (tiny raster) for scheduling, instance B
//          (full 800-clock lines, 6-line frame) for timing and pixel colours.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pattern_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_errors = 0;
    int   idx_glitch = 0;
    logic [1:0] prev_idx_a;

    pattern_scheduler_if bus_a();
    pattern_scheduler_if bus_b();

    // A: 48 clocks x 8 lines = 384-clock frame.
    pattern_scheduler #(
        .H_ACTIVE (32), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_ACTIVE (4),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) dut_a (.pixelClk (clk), .reset (rst_a), .bus (bus_a));

    // B: standard 800-clock line, 2 active + 1 + 2 + 1 lines = 4800-clock frame.
    pattern_scheduler #(
        .H_ACTIVE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_ACTIVE (2),   .V_FRONT (1),  .V_SYNC (2),  .V_BACK (1)
    ) dut_b (.pixelClk (clk), .reset (rst_b), .bus (bus_b));

    logic [1:0] seq_hold2 [9]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [1:0] seq_mask  [5]  = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] outs_a();
        return {bus_a.hSync, bus_a.vSync, bus_a.dataEnable, bus_a.frameStart, bus_a.patternIdx,
                bus_a.vgaRed, bus_a.vgaGreen, bus_a.vgaBlue};
    endfunction

    function automatic logic [29:0] outs_b();
        return {bus_b.hSync, bus_b.vSync, bus_b.dataEnable, bus_b.frameStart, bus_b.patternIdx,
                bus_b.vgaRed, bus_b.vgaGreen, bus_b.vgaBlue};
    endfunction

    function automatic logic [24:0] pix_a();
        return {bus_a.dataEnable, bus_a.vgaRed, bus_a.vgaGreen, bus_a.vgaBlue};
    endfunction

    function automatic logic [24:0] pix_b();
        return {bus_b.dataEnable, bus_b.vgaRed, bus_b.vgaGreen, bus_b.vgaBlue};
    endfunction

    task automatic next_fs_a(output logic [1:0] idx, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.frameStart && n < 1000);
        if (!bus_a.frameStart) check("a_fs_timeout", 32'd0, 32'd1);
        idx = bus_a.patternIdx;
    endtask

    task automatic next_fs_b(output logic [1:0] idx, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_b.frameStart && n < 10000);
        if (!bus_b.frameStart) check("b_fs_timeout", 32'd0, 32'd1);
        idx = bus_b.patternIdx;
    endtask

    task automatic pulse_reset_a();
        @(posedge clk); #2 rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b1;
    endtask

    // patternIdx may only change on the frameStart cycle (outside reset).
    always @(negedge clk) begin
        if (!rst_a) begin
            prev_idx_a <= 2'd0;
        end else begin
            if (bus_a.patternIdx !== prev_idx_a && !bus_a.frameStart) idx_glitch <= idx_glitch + 1;
            prev_idx_a <= bus_a.patternIdx;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] idx;
        int n, hfall, hlow, vlow, de_cnt, fs_cnt, blank_bad, last_fall, hper, last_fs, fs_gap;
        logic hs_prev;

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.holdFrames = 8'd2;   bus_a.patternMask = 4'hF;    bus_a.forceNext = 1'b0;
        bus_b.holdFrames = 8'd100; bus_b.patternMask = 4'b0100; bus_b.forceNext = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("a_reset_outputs", 32'(outs_a()), 32'({2'b11, 28'h0}));
        check("b_reset_outputs", 32'(outs_b()), 32'({2'b11, 28'h0}));

        // Released 2 ns after a rising edge: frameStart shows after the next rising edge,
        // i.e. at the second falling edge.
        rst_a = 1'b1;
        next_fs_a(idx, n);
        check("a_first_fs_latency", n, 2);
        check("a_hold2_f0", idx, seq_hold2[0]);
        for (int f = 1; f < 9; f++) begin
            next_fs_a(idx, n);
            check($sformatf("a_hold2_f%0d", f), idx, seq_hold2[f]);
            check($sformatf("a_hold2_period_f%0d", f), n, 384);
        end

        bus_a.patternMask = 4'b1010;
        bus_a.holdFrames  = 8'd1;
        pulse_reset_a();
        for (int f = 0; f < 5; f++) begin
            next_fs_a(idx, n);
            check($sformatf("a_mask1010_f%0d", f), idx, seq_mask[f]);
            if (f == 1) check("a_blue_px", pix_a(), {1'b1, 24'h0000FF});
        end
        bus_a.patternMask = 4'b0000;
        next_fs_a(idx, n);
        check("a_mask0_idx_f5", idx, 2'd3);
        check("a_mask0_black_px", pix_a(), {1'b1, 24'h000000});
        next_fs_a(idx, n);
        check("a_mask0_idx_f6", idx, 2'd3);
        bus_a.patternMask = 4'hF;
        next_fs_a(idx, n);
        check("a_unmask_idx_f7", idx, 2'd0);
        check("a_red_px", pix_a(), {1'b1, 24'hFF0000});

        bus_a.holdFrames = 8'd10;
        pulse_reset_a();
        for (int f = 0; f < 16; f++) begin
            next_fs_a(idx, n);
            check($sformatf("a_force_f%0d", f), idx, (f < 4) ? 2'd0 : (f < 14) ? 2'd1 : 2'd2);
            if (f == 3 || f == 13) begin
                repeat (20) @(negedge clk);
                bus_a.forceNext = 1'b1;
                @(negedge clk);
                bus_a.forceNext = 1'b0;
            end
        end
        check("a_idx_only_on_fs", idx_glitch, 0);

        @(posedge clk); #2 rst_b = 1'b1;
        next_fs_b(idx, n);
        check("b_first_fs_latency", n, 2);
        check("b_f0_red_px", pix_b(), {1'b1, 24'hFF0000});
        hfall = 0; hlow = 0; vlow = 0; de_cnt = 0; fs_cnt = 0; blank_bad = 0;
        last_fall = -1; hper = 0; last_fs = -1; fs_gap = 0; hs_prev = 1'b1;
        for (int i = 0; i < 9600; i++) begin
            if (i > 0) @(negedge clk);
            if (!bus_b.hSync) hlow++;
            if (!bus_b.hSync && hs_prev) begin
                if (last_fall >= 0) hper = i - last_fall;
                last_fall = i;
                hfall++;
            end
            hs_prev = bus_b.hSync;
            if (!bus_b.vSync) vlow++;
            if (bus_b.dataEnable) de_cnt++;
            else if ({bus_b.vgaRed, bus_b.vgaGreen, bus_b.vgaBlue} != 24'h0) blank_bad++;
            if (bus_b.frameStart) begin
                if (last_fs >= 0) fs_gap = i - last_fs;
                last_fs = i;
                fs_cnt++;
            end
        end
        check("b_hsync_falls", hfall, 12);
        check("b_hsync_period", hper, 800);
        check("b_hsync_low", hlow, 12 * 96);
        check("b_vsync_low", vlow, 2 * 1600);
        check("b_de_count", de_cnt, 2 * 640 * 2);
        check("b_fs_count", fs_cnt, 2);
        check("b_fs_period", fs_gap, 4800);
        check("b_blank_black", blank_bad, 0);

        next_fs_b(idx, n);
        check("b_bars_idx", idx, 2'd2);
        check("b_bars_x0", pix_b(), {1'b1, 24'hFFFFFF});
        repeat (79) @(negedge clk);
        check("b_bars_x79", pix_b(), {1'b1, 24'hFFFFFF});
        @(negedge clk);
        check("b_bars_x80", pix_b(), {1'b1, 24'hFFFF00});
        repeat (559) @(negedge clk);
        check("b_bars_x639", pix_b(), {1'b1, 24'h000000});
        @(negedge clk);
        check("b_bars_x640_blank", pix_b(), {1'b0, 24'h000000});
        bus_b.patternMask = 4'b1000;

        next_fs_b(idx, n);
        check("b_checker_idx", idx, 2'd3);
        repeat (31) @(negedge clk);
        check("b_checker_x31", pix_b(), {1'b1, 24'hFFFFFF});
        @(negedge clk);
        check("b_checker_x32", pix_b(), {1'b1, 24'h000000});
        repeat (32) @(negedge clk);
        check("b_checker_x64", pix_b(), {1'b1, 24'hFFFFFF});

        repeat (236) @(negedge clk);
        #3 rst_b = 1'b0;
        #1;
        check("b_async_reset", 32'(outs_b()), 32'({2'b11, 28'h0}));
        @(posedge clk); #2 rst_b = 1'b1;
        next_fs_b(idx, n);
        check("b_restart_latency", n, 2);
        check("b_restart_idx", idx, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
